// File: rtl/signed_seq_divider_if.sv
// Load/done handshake bundle shared by the sequential divider and its controller.
// The master side issues operands, and the slave side returns the result flags.
interface signed_seq_divider_if #(
  parameter int unsigned W = 8
);
  logic           load;
  logic [2*W-1:0] dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic [W-1:0]   quotient;
  logic [W-1:0]   remainder;
  logic           ovf;
  logic           div_zero;

  modport master (
    output load, dividend, divisor,
    input  busy, done, quotient, remainder, ovf, div_zero
  );

  modport slave (
    input  load, dividend, divisor,
    output busy, done, quotient, remainder, ovf, div_zero
  );
endinterface

// File: rtl/signed_seq_divider.sv
// Signed 2W/W divider: restoring division on magnitudes, one step per clock.
// After the last step, a fix-up cycle applies signs and saturates on overflow.
module signed_seq_divider #(
  parameter int unsigned W = 8
) (
  input logic                  clk,
  input logic                  reset,
  signed_seq_divider_if.slave  div_if
);
  localparam int unsigned CntW = $clog2(2 * W);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic            sd_q, sd_d, sv_q, sv_d;
  logic [2*W-1:0]  dvd_q, dvd_d;
  logic [W-1:0]    dvs_q, dvs_d;
  logic [W:0]      prem_q, prem_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            busy_q, busy_d, done_q, done_d, ovf_q, ovf_d, dz_q, dz_d;
  logic [W-1:0]    quo_q, quo_d, rem_q, rem_d;

  logic            div_is_zero, last_step, neg_res, q_fits;
  logic [W+1:0]    prem_sh, trial;
  logic [2*W-1:0]  q_lim;

  assign div_is_zero = (div_if.divisor == '0);
  assign last_step   = (cnt_q == CntW'(2 * W - 1));
  // Dividend register doubles as the quotient shift register.
  assign prem_sh     = {prem_q, dvd_q[2*W-1]};
  assign trial       = prem_sh - {2'b00, dvs_q};
  assign neg_res     = sd_q ^ sv_q;
  assign q_lim       = neg_res ? {{W{1'b0}}, 1'b1, {(W-1){1'b0}}}
                               : {{(W+1){1'b0}}, {(W-1){1'b1}}};
  assign q_fits      = (dvd_q <= q_lim);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (div_if.load) begin
      state_d = div_is_zero ? StDone : StCalc;
    end else begin
      case (state_q)
        StCalc:  if (last_step) state_d = StFix;
        StFix:   state_d = StDone;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    sd_d   = sd_q;
    sv_d   = sv_q;
    dvd_d  = dvd_q;
    dvs_d  = dvs_q;
    prem_d = prem_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    done_d = done_q;
    ovf_d  = ovf_q;
    dz_d   = dz_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    if (div_if.load) begin
      sd_d   = div_if.dividend[2*W-1];
      sv_d   = div_if.divisor[W-1];
      dvd_d  = div_if.dividend[2*W-1] ? -div_if.dividend : div_if.dividend;
      dvs_d  = div_if.divisor[W-1] ? -div_if.divisor : div_if.divisor;
      prem_d = '0;
      cnt_d  = '0;
      done_d = 1'b0;
      ovf_d  = 1'b0;
      dz_d   = 1'b0;
      busy_d = !div_is_zero;
      if (div_is_zero) begin
        dz_d   = 1'b1;
        done_d = 1'b1;
        quo_d  = '0;
        rem_d  = '0;
      end
    end else begin
      case (state_q)
        StCalc: begin
          cnt_d = cnt_q + 1'b1;
          if (!trial[W+1]) begin
            prem_d = trial[W:0];
            dvd_d  = {dvd_q[2*W-2:0], 1'b1};
          end else begin
            prem_d = prem_sh[W:0];
            dvd_d  = {dvd_q[2*W-2:0], 1'b0};
          end
        end
        StFix: begin
          ovf_d = !q_fits;
          if (q_fits) begin
            quo_d = neg_res ? -dvd_q[W-1:0] : dvd_q[W-1:0];
          end else begin
            quo_d = neg_res ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
          end
          rem_d  = sd_q ? -prem_q[W-1:0] : prem_q[W-1:0];
          done_d = 1'b1;
          busy_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sd_q   <= 1'b0;
      sv_q   <= 1'b0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      prem_q <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      ovf_q  <= 1'b0;
      dz_q   <= 1'b0;
      quo_q  <= '0;
      rem_q  <= '0;
    end else begin
      sd_q   <= sd_d;
      sv_q   <= sv_d;
      dvd_q  <= dvd_d;
      dvs_q  <= dvs_d;
      prem_q <= prem_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
      ovf_q  <= ovf_d;
      dz_q   <= dz_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
    end
  end

  assign div_if.busy      = busy_q;
  assign div_if.done      = done_q;
  assign div_if.ovf       = ovf_q;
  assign div_if.div_zero  = dz_q;
  assign div_if.quotient  = quo_q;
  assign div_if.remainder = rem_q;
endmodule
